riscv_obi_gnt_stall: RTL

RISCV_OBI_GNT_STALL -- requirements
Module: riscv_obi_gnt_stall

---
 rtl/riscv_obi_gnt_stall.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/riscv_obi_gnt_stall.sv
// OBI request/grant stall injector: per-channel FSM holds back the core request
// for a fixed or pseudo-random number of cycles before forwarding it to memory.
module riscv_obi_gnt_stall #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_W     = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2BAD
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       req_core_i,
    output logic [NUM_CH-1:0]       req_mem_o,
    input  logic [NUM_CH-1:0]       gnt_mem_i,
    output logic [NUM_CH-1:0]       gnt_core_o,
    input  logic [NUM_CH-1:0]       en_stall_i,
    input  logic [2*NUM_CH-1:0]     stall_mode_i,
    input  logic [CNT_W*NUM_CH-1:0] gnt_stall_i,
    input  logic [CNT_W*NUM_CH-1:0] max_stall_i,
    output logic [32*NUM_CH-1:0]    stall_cycles_o,
    output logic [NUM_CH-1:0]       protocol_err_o
);

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_PASS  = 2'd2
    } state_e;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [31:0] SEED_RAW = LFSR_SEED + 32'(c);
        localparam logic [31:0] SEED     = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;

        state_e           r_state;
        state_e           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_delay;
        logic [CNT_W-1:0] w_cfg_fix;
        logic [CNT_W-1:0] w_cfg_max;
        logic [CNT_W:0]   w_rand;
        logic [1:0]       w_mode;
        logic [31:0]      r_lfsr;
        logic [31:0]      r_stall_cnt;
        logic             r_err;
        logic             w_req;
        logic             w_gnt;
        logic             w_err_set;
        logic             w_stalling;
        logic             w_req_mem;

        assign w_req     = req_core_i[c];
        assign w_gnt     = gnt_mem_i[c];
        assign w_mode    = stall_mode_i[2*c +: 2];
        assign w_cfg_fix = gnt_stall_i[CNT_W*c +: CNT_W];
        assign w_cfg_max = max_stall_i[CNT_W*c +: CNT_W];

        // Extra bit keeps max+1 from wrapping when max is all ones.
        assign w_rand = (CNT_W+1)'(r_lfsr[CNT_W-1:0]) % ((CNT_W+1)'(w_cfg_max) + (CNT_W+1)'(1));

        always_comb begin
            w_delay = '0;
            if (en_stall_i[c]) begin
                case (w_mode)
                    2'd1:    w_delay = w_cfg_fix;
                    2'd2:    w_delay = CNT_W'(w_rand);
                    default: w_delay = '0;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= S_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // The IDLE decision cycle is the first stalled cycle, so STALL lasts d-1 cycles.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_err_set   = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_delay == '0) begin
                            if (!w_gnt) w_state_nxt = S_PASS;
                        end else if (w_delay == CNT_W'(1)) begin
                            w_state_nxt = S_PASS;
                        end else begin
                            w_state_nxt = S_STALL;
                            w_cnt_nxt   = w_delay - CNT_W'(1);
                        end
                    end
                end
                S_STALL: begin
                    if (!w_req) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_PASS;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                    end
                end
                S_PASS: begin
                    if (!w_req) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_gnt) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        always_comb begin
            w_req_mem  = 1'b0;
            w_stalling = 1'b0;
            case (r_state)
                S_IDLE: begin
                    w_req_mem  = w_req & (w_delay == '0);
                    w_stalling = w_req & (w_delay != '0);
                end
                S_STALL: w_stalling = 1'b1;
                S_PASS:  w_req_mem  = w_req;
                default: w_req_mem  = 1'b0;
            endcase
            if (!rst_ni) begin
                w_req_mem  = 1'b0;
                w_stalling = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt       <= '0;
                r_lfsr      <= SEED;
                r_err       <= 1'b0;
                r_stall_cnt <= '0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
                r_err  <= r_err | w_err_set;
                if (w_stalling && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                    r_stall_cnt <= r_stall_cnt + 32'd1;
                end
            end
        end

        assign req_mem_o[c]              = w_req_mem;
        assign gnt_core_o[c]             = w_req_mem & w_gnt;
        assign stall_cycles_o[32*c +: 32] = r_stall_cnt;
        assign protocol_err_o[c]         = r_err;
    end

endmodule
